// File: rtl/dma_path_responder_if.sv
// DMA path bundle between the initiator (master) and the terminating responder (slave).
// A beat moves on any rising clk edge where valid and ready are both high; valid never waits on ready.
interface dma_path_responder_if;
  logic         dma_req;
  logic         dma_resp;
  logic         dma_write_valid;
  logic [127:0] dma_write_data;
  logic         dma_write_ready;
  logic         dma_read_valid;
  logic [127:0] dma_read_data;
  logic         dma_read_ready;

  modport master (
    output dma_req, dma_write_valid, dma_write_data, dma_read_ready,
    input  dma_resp, dma_write_ready, dma_read_valid, dma_read_data
  );

  modport slave (
    input  dma_req, dma_write_valid, dma_write_data, dma_read_ready,
    output dma_resp, dma_write_ready, dma_read_valid, dma_read_data
  );
endinterface

// File: rtl/dma_path_responder.sv
// Terminating responder of the DMA path: grants, decodes the header, moves beats to/from local SRAM.
// Optional DMA_PROTO_CHECK_EN adds a sticky proto_err output and rejects malformed headers.
module dma_path_responder #(
  parameter int LOCAL_AW  = 14,
  parameter int RFIFO_DEP = 2
) (
  input  logic                clk,
  input  logic                reset,
  dma_path_responder_if.slave dma,
  output logic                mem_en,
  output logic                mem_we,
  output logic [LOCAL_AW-1:0] mem_addr,
  output logic [127:0]        mem_wdata,
  input  logic [127:0]        mem_rdata,
  output logic                busy,
`ifdef DMA_PROTO_CHECK_EN
  output logic                proto_err,
`endif
  output logic [2:0]          state_dbg
);

  localparam int PW = $clog2(RFIFO_DEP);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_HDR   = 3'd2,
    S_WDATA = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [LOCAL_AW-1:0] addr_q;
  logic [15:0]         len_q, cnt_q, pop_q;
  logic                inflight_q;
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       fcnt_q;
  logic [127:0]        fifo_mem [RFIFO_DEP];

  logic          hdr_fire, wr_beat, issue, pop, hdr_bad, hdr_is_wr;
  logic [15:0]   hdr_len;
  logic [CW:0]   occ;

  assign hdr_fire  = (state_q == S_HDR) && dma.dma_write_valid;
  assign wr_beat   = (state_q == S_WDATA) && dma.dma_write_valid;
  assign hdr_len   = dma.dma_write_data[69:54];
  assign state_dbg = state_q;

`ifdef DMA_PROTO_CHECK_EN
  assign hdr_is_wr = (dma.dma_write_data[77:70] == 8'h03);
  assign hdr_bad   = ((dma.dma_write_data[77:70] != 8'h01) && (dma.dma_write_data[77:70] != 8'h03))
                     || (|dma.dma_write_data[127:78]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   proto_err <= 1'b0;
    else if (hdr_fire && hdr_bad) proto_err <= 1'b1;
  end
`else
  assign hdr_is_wr = dma.dma_write_data[71];
  assign hdr_bad   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dma.dma_req) state_d = S_GRANT;
      S_GRANT: state_d = S_HDR;
      S_HDR: begin
        if (hdr_fire) begin
          if (hdr_bad || (hdr_len == 16'd0)) state_d = S_DONE;
          else if (hdr_is_wr)                state_d = S_WDATA;
          else                               state_d = S_RDATA;
        end
      end
      S_WDATA: if (wr_beat && (cnt_q == len_q - 16'd1)) state_d = S_DONE;
      S_RDATA: if (pop && (pop_q == len_q - 16'd1))     state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dma.dma_resp        = 1'b0;
    dma.dma_write_ready = 1'b0;
    dma.dma_read_valid  = 1'b0;
    dma.dma_read_data   = '0;
    mem_en              = 1'b0;
    mem_we              = 1'b0;
    mem_wdata           = '0;
    issue               = 1'b0;
    pop                 = 1'b0;
    occ                 = '0;
    busy                = (state_q != S_IDLE);
    case (state_q)
      S_GRANT: dma.dma_resp = 1'b1;
      S_HDR:   dma.dma_write_ready = 1'b1;
      S_WDATA: begin
        dma.dma_write_ready = 1'b1;
        mem_en              = dma.dma_write_valid;
        mem_we              = dma.dma_write_valid;
        mem_wdata           = dma.dma_write_valid ? dma.dma_write_data : '0;
      end
      S_RDATA: begin
        dma.dma_read_valid = (fcnt_q != '0);
        dma.dma_read_data  = dma.dma_read_valid ? fifo_mem[rptr_q] : '0;
        pop                = dma.dma_read_valid && dma.dma_read_ready;
        // A pop this cycle frees a slot in time for a read issued now, keeping the stream bubble-free.
        occ   = {1'b0, fcnt_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue = (cnt_q < len_q) && (occ < (CW+1)'(RFIFO_DEP));
        mem_en = issue;
      end
      default: ;
    endcase
  end

  assign mem_addr = addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      pop_q      <= '0;
      inflight_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fcnt_q     <= '0;
    end else begin
      inflight_q <= issue;
      if (hdr_fire) begin
        addr_q <= dma.dma_write_data[LOCAL_AW-1:0];
        len_q  <= hdr_len;
        cnt_q  <= '0;
        pop_q  <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
        fcnt_q <= '0;
      end else begin
        if (wr_beat || issue) begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q + 16'd1;
        end
        if (inflight_q) wptr_q <= wptr_q + 1'b1;
        if (pop) begin
          rptr_q <= rptr_q + 1'b1;
          pop_q  <= pop_q + 16'd1;
        end
        fcnt_q <= fcnt_q + CW'(inflight_q) - CW'(pop);
      end
    end
  end

  // SRAM data is valid the cycle after issue, which is exactly when inflight_q is high.
  always_ff @(posedge clk) begin
    if (inflight_q) fifo_mem[wptr_q] <= mem_rdata;
  end

endmodule
